// File: rtl/avalon_ibex_bridge_pkg.sv
// Shared types and the address translation helper for the ibex-to-Avalon bridge.
package avalon_ibex_pkg;

  typedef enum logic [1:0] {
    OKAY      = 2'b00,
    RESERVED  = 2'b01,
    SLVERR    = 2'b10,
    DECODEERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_RD   = 2'b01,
    CMD_WR   = 2'b10
  } cmd_state_e;

  // Widest address the helper handles; callers truncate to their own width.
  localparam int unsigned XlateWidth = 64;

  function automatic logic [XlateWidth-1:0] addr_xlate(input logic [XlateWidth-1:0] addr,
                                                       input bit                    word_addr,
                                                       input int unsigned           be_width);
    if (!word_addr) begin
      return addr;
    end
    return (be_width == 8) ? (addr >> 3) : (addr >> 2);
  endfunction

endpackage

// File: rtl/avalon_ibex_bridge_if.sv
// Core LSU handshake plus Avalon-MM master signals carried by the bridge.
interface avalon_ibex_bridge_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic                 req_i;
  logic                 we_i;
  logic [BeWidth-1:0]   be_i;
  logic [AddrWidth-1:0] addr_i;
  logic [DataWidth-1:0] wdata_i;
  logic                 gnt_o;
  logic                 rvalid_o;
  logic [DataWidth-1:0] rdata_o;
  logic                 err_o;

  logic [AddrWidth-1:0] avm_address;
  logic [BeWidth-1:0]   avm_byteenable;
  logic                 avm_read;
  logic                 avm_write;
  logic [DataWidth-1:0] avm_writedata;
  logic                 avm_waitrequest;
  logic                 avm_readdatavalid;
  logic [DataWidth-1:0] avm_readdata;
  logic [1:0]           avm_response;

  // Bridge side: slave to the core, master on Avalon.
  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    input  avm_waitrequest, avm_readdatavalid, avm_readdata, avm_response,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
  );

  // Environment side: drives the core requests and models the Avalon fabric.
  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    output avm_waitrequest, avm_readdatavalid, avm_readdata, avm_response,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
  );

endinterface

// File: rtl/avalon_ibex_bridge.sv
// Bridges the ibex req/gnt/rvalid LSU protocol to a pipelined Avalon-MM master
// with up to MaxOutstanding reads in flight and in-order responses.
module avalon_ibex_bridge
  import avalon_ibex_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned WordAddr       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  avalon_ibex_bridge_if.slave   bus_io,
  output logic                  busy_o
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
  localparam int unsigned OccW    = CntW + 1;

  cmd_state_e           state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [BeWidth-1:0]   be_q, be_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]      rd_cnt_q, rd_cnt_d;
  logic                 wr_resp_pend_q, wr_resp_pend_d;
  logic                 rvalid_q, rvalid_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                  cmd_free, rd_inflight, rd_retire, wr_retire, rsp_dec;
  logic                  can_rd, can_wr, gnt;
  logic [OccW-1:0]       rd_occ;
  logic [XlateWidth-1:0] addr_wide;
  logic                  unused_xlate;

  assign cmd_free    = (state_q == CMD_IDLE) | ~bus_io.avm_waitrequest;
  assign rd_inflight = (state_q == CMD_RD);
  assign rd_retire   = (state_q == CMD_RD) & ~bus_io.avm_waitrequest;
  assign wr_retire   = (state_q == CMD_WR) & ~bus_io.avm_waitrequest;
  // Late data with nothing outstanding (e.g. after reset) is dropped.
  assign rsp_dec     = bus_io.avm_readdatavalid & (rd_cnt_q != '0);

  // Occupancy counts the read sitting in the command register and credits a
  // same-cycle return, so a full pipe reopens the moment data comes back.
  assign rd_occ = OccW'(rd_cnt_q) + OccW'(rd_inflight) - OccW'(rsp_dec);

  assign can_rd = cmd_free & ~wr_resp_pend_q
                & ~((state_q == CMD_WR) & bus_io.avm_waitrequest)
                & (rd_occ < OccW'(MaxOutstanding));
  assign can_wr = cmd_free & (rd_cnt_q == '0) & (state_q != CMD_RD) & ~wr_resp_pend_q;
  assign gnt    = ~rst_i & bus_io.req_i & (bus_io.we_i ? can_wr : can_rd);

  assign addr_wide    = addr_xlate(XlateWidth'(bus_io.addr_i), WordAddr != 0, BeWidth);
  assign unused_xlate = ^addr_wide;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    if (gnt) begin
      addr_d  = addr_wide[AddrWidth-1:0];
      be_d    = bus_io.be_i;
      wdata_d = bus_io.wdata_i;
      state_d = bus_io.we_i ? CMD_WR : CMD_RD;
    end else if (cmd_free) begin
      state_d = CMD_IDLE;
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    unique case ({rd_retire, rsp_dec})
      2'b10:   rd_cnt_d = rd_cnt_q + CntW'(1);
      2'b01:   rd_cnt_d = rd_cnt_q - CntW'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase
    wr_resp_pend_d = wr_retire;
    rvalid_d       = rsp_dec | wr_retire;
    rdata_d        = rsp_dec ? bus_io.avm_readdata : '0;
    err_d          = rsp_dec & (bus_io.avm_response != OKAY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= CMD_IDLE;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      rd_cnt_q       <= '0;
      wr_resp_pend_q <= 1'b0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      rd_cnt_q       <= rd_cnt_d;
      wr_resp_pend_q <= wr_resp_pend_d;
      rvalid_q       <= rvalid_d;
      rdata_q        <= rdata_d;
      err_q          <= err_d;
    end
  end

  assign bus_io.gnt_o          = gnt;
  assign bus_io.rvalid_o       = rvalid_q;
  assign bus_io.rdata_o        = rdata_q;
  assign bus_io.err_o          = err_q;
  assign bus_io.avm_address    = addr_q;
  assign bus_io.avm_byteenable = be_q;
  assign bus_io.avm_writedata  = wdata_q;
  assign bus_io.avm_read       = (state_q == CMD_RD);
  assign bus_io.avm_write      = (state_q == CMD_WR);

  assign busy_o = (state_q != CMD_IDLE) | (rd_cnt_q != '0) | wr_resp_pend_q;

endmodule

// File: doc/avalon_ibex_bridge.md
Name: avalon_ibex_bridge

Overview:
Parametrised successor to the single-transaction Avalon data translators. It bridges the ibex req/gnt/rvalid LSU protocol to a pipelined Avalon-MM master with up to MaxOutstanding reads in flight. It supports configurable address/data width and a selectable word/byte address mode. It sits between ibex_core's data port and the system interconnect in ibex_core_avalon-style wrappers, and can replace both the main and instr translators.

Parameters:
AddrWidth, 32, width of core and Avalon address.
DataWidth, 32, data bus width; must be 32 or 64; BeWidth = DataWidth/8.
MaxOutstanding, 4, maximum accepted-but-unreturned Avalon reads (1..15).
WordAddr, 1, 1: avm_address = addr_i >> log2(BeWidth), zero-filled at top; 0: byte address passed through unchanged.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_i  in  1  core request
we_i  in  1  1 = write
be_i  in  BeWidth  byte enables
addr_i  in  AddrWidth  byte address from core
wdata_i  in  DataWidth  write data
gnt_o  out  1  request accepted (combinational)
rvalid_o  out  1  response valid (registered)
rdata_o  out  DataWidth  read data (registered)
err_o  out  1  response error, qualified by rvalid_o
avm_address  out  AddrWidth  Avalon address
avm_byteenable  out  BeWidth  Avalon byte enables
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_writedata  out  DataWidth  Avalon write data
avm_waitrequest  in  1  Avalon stall
avm_readdatavalid  in  1  Avalon read data valid
avm_readdata  in  DataWidth  Avalon read data
avm_response  in  2  Avalon response code
busy_o  out  1  command pending or reads outstanding

Behaviour:
- Reset (rst_i sampled high at clk_i edge): all outputs 0. State = CMD_IDLE. rd_cnt = 0. wr_resp_pend = 0.
- Command register FSM:
  - CMD_IDLE: no Avalon command driven.
  - CMD_RD / CMD_WR: avm_read or avm_write is high. Address, byteenable and writedata are held stable while avm_waitrequest = 1.
- cmd_free = (state == CMD_IDLE) | ~avm_waitrequest. A pending command retiring this cycle frees the slot, which allows back-to-back issue.
- Read acceptance: can_rd = cmd_free & ~wr_resp_pend & ~(state == CMD_WR & avm_waitrequest) & (rd_cnt + inflight_rd < MaxOutstanding).
- Write acceptance: can_wr = cmd_free & (rd_cnt == 0) & (state != CMD_RD) & ~wr_resp_pend. Writes never overtake reads, so responses stay in order.
- gnt_o = req_i & (we_i ? can_wr : can_rd). On grant, the command register loads addr, be and wdata, and the next state is CMD_RD or CMD_WR. With no grant and the command retired, the next state is CMD_IDLE.
- rd_cnt increments when a read is retired to Avalon (CMD_RD & ~avm_waitrequest). It decrements on avm_readdatavalid. If both happen in the same cycle, it is unchanged. Width is clog2(MaxOutstanding+1).
- Read response: 1 cycle after avm_readdatavalid, rvalid_o = 1, rdata_o = readdata, err_o = (avm_response != OKAY).
- Write response: a write retired in cycle N sets wr_resp_pend. In cycle N+1, rvalid_o = 1, err_o = 0, rdata_o = 0.
- No collision is possible: a write is only issued with rd_cnt == 0, and reads are blocked while wr_resp_pend is set.
- Spurious avm_readdatavalid with rd_cnt == 0 (for example, late data after reset) is ignored. No rvalid_o, no underflow.
- Full: with rd_cnt == MaxOutstanding, gnt_o stays 0 for reads. Read grant resumes in the same cycle readdatavalid decrements the count.
- Reset mid-operation: the command is dropped immediately and the counters clear. The core is also in reset, so no response is owed.
- busy_o = (state != CMD_IDLE) | (rd_cnt != 0) | wr_resp_pend.

Decomposition:
- Package avalon_ibex_pkg holds:
  - resp_e: OKAY = 2'b00, RESERVED = 2'b01, SLVERR = 2'b10, DECODEERR = 2'b11.
  - cmd_state_e: CMD_IDLE, CMD_RD, CMD_WR.
  - Function addr_xlate(addr, WordAddr, BeWidth).
- Single module; the outstanding counter is inline. No sub-module is warranted.

Test Plan:
- Single read, WordAddr = 1: addr_i = 0x0000_0104, waitrequest = 0, readdatavalid 2 cycles later with data 0xDEADBEEF. Required: gnt_o same cycle, avm_address = 0x41, rvalid_o with rdata_o = 0xDEADBEEF, err_o = 0.
- Pipelined reads, MaxOutstanding = 4: 6 back-to-back read reqs, readdatavalid withheld. Required: exactly 4 grants, gnt_o low on the 5th. A 5th grant is issued the cycle the first readdatavalid arrives. 6 rvalids are returned in order.
- Waitrequest hold: write 0x1234_5678, be = 4'b0011, waitrequest = 1 for 3 cycles. Required: avm_* stable for 4 cycles, then rvalid_o 1 cycle after release.
- Ordering: read granted and pending (rd_cnt = 1), then write req. Required: gnt_o for the write stays 0 until the read response, and the write's rvalid_o follows the read's rvalid_o.
- Error: read with avm_response = 2'b10. Required: rvalid_o = 1, err_o = 1.
- Reset mid-flight: rst_i during rd_cnt = 3, then 3 late readdatavalids. Required: no rvalid_o, rd_cnt = 0, busy_o = 0.
